// File: rtl/expr_eval.sv
// ---------------------------------------------------------------------------
// expr_eval : evaluates "d(op d)*=" ASCII expressions, '*' binds tighter than '+'
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module expr_eval #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_DIG = 2'd0,
    S_OP  = 2'd1,
    S_ERR = 2'd2
  } state_t;

  typedef enum logic {
    M_NEW = 1'b0,
    M_MUL = 1'b1
  } mode_t;

  state_t       state_q, state_d;
  mode_t        mode_q, mode_d;
  logic [W-1:0] sum_q, sum_d;
  logic [W-1:0] term_q, term_d;
  logic [W-1:0] result_q, result_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;

  logic         is_dig, is_plus, is_star, is_eq;
  logic [W-1:0] dig_w;
  logic [W-1:0] prod_w;

  assign is_dig  = (in >= 8'h30) && (in <= 8'h39);
  assign is_plus = (in == 8'h2B);
  assign is_star = (in == 8'h2A);
  assign is_eq   = (in == 8'h3D);
  assign dig_w   = W'(in - 8'h30);
  assign prod_w  = term_q * dig_w;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sum_d    = sum_q;
    term_d   = term_q;
    result_d = result_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (in_valid) begin
      case (state_q)
        S_DIG: begin
          if (is_dig) begin
            term_d  = (mode_q == M_MUL) ? prod_w : dig_w;
            state_d = S_OP;
            busy_d  = 1'b1;
          end else if (is_eq) begin
            // A bare '=' while idle is ignored; after an operator it terminates with error.
            if (busy_q) begin
              result_d = '0;
              err_d    = 1'b1;
              done_d   = 1'b1;
              sum_d    = '0;
              term_d   = '0;
              mode_d   = M_NEW;
              busy_d   = 1'b0;
            end
          end else begin
            state_d = S_ERR;
            busy_d  = 1'b1;
          end
        end
        S_OP: begin
          if (is_plus) begin
            sum_d   = sum_q + term_q;
            mode_d  = M_NEW;
            state_d = S_DIG;
          end else if (is_star) begin
            mode_d  = M_MUL;
            state_d = S_DIG;
          end else if (is_eq) begin
            result_d = sum_q + term_q;
            err_d    = 1'b0;
            done_d   = 1'b1;
            sum_d    = '0;
            term_d   = '0;
            mode_d   = M_NEW;
            busy_d   = 1'b0;
            state_d  = S_DIG;
          end else begin
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (is_eq) begin
            result_d = '0;
            err_d    = 1'b1;
            done_d   = 1'b1;
            sum_d    = '0;
            term_d   = '0;
            mode_d   = M_NEW;
            busy_d   = 1'b0;
            state_d  = S_DIG;
          end
        end
        default: state_d = S_DIG;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_DIG;
      mode_q   <= M_NEW;
      sum_q    <= '0;
      term_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_expr_eval.sv
// ---------------------------------------------------------------------------
// tb_expr_eval : directed + random expression streams against a string-level evaluator
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_expr_eval;

  typedef logic [7:0] bq_t[$];

  logic        clk;
  logic        clr;
  logic [7:0]  in;
  logic        in_valid;
  logic [15:0] result;
  logic        done;
  logic        err;
  logic        busy;

  int n_chk;
  int n_fail;

  // Reference state: characters of the pending expression and the expected outputs.
  bq_t         pend;
  logic [15:0] m_res;
  logic        m_err;
  logic        m_busy;

  expr_eval #(.W(16)) dut (
    .clk      (clk),
    .clr      (clr),
    .in       (in),
    .in_valid (in_valid),
    .result   (result),
    .done     (done),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Evaluate a whole expression body: digits at even positions, operators between.
  function automatic void model(input bq_t q, output logic ok, output logic [15:0] v);
    int unsigned s;
    int unsigned p;
    s  = 0;
    p  = 1;
    ok = (q.size() % 2) == 1;
    foreach (q[i]) begin
      if (i % 2 == 0) begin
        if (q[i] >= 8'h30 && q[i] <= 8'h39) p = (p * (q[i] - 8'h30)) % 65536;
        else ok = 1'b0;
      end else if (q[i] == 8'h2B) begin
        s = (s + p) % 65536;
        p = 1;
      end else if (q[i] != 8'h2A) begin
        ok = 1'b0;
      end
    end
    s = (s + p) % 65536;
    v = ok ? s[15:0] : 16'h0;
  endfunction

  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic check_outs(input string tag, input logic exp_done);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, ".result"}, {16'd0, result}, {16'd0, m_res});
    chk({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in       = 8'($urandom);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_outs("idle", 1'b0);
  endtask

  task automatic send_char(input logic [7:0] c);
    logic        ok;
    logic [15:0] v;
    logic        exp_done;
    @(negedge clk);
    in       = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_done = 1'b0;
    if (c == 8'h3D) begin
      if (pend.size() != 0) begin
        model(pend, ok, v);
        m_res    = v;
        m_err    = ~ok;
        m_busy   = 1'b0;
        exp_done = 1'b1;
        pend.delete();
      end
    end else begin
      pend.push_back(c);
      m_busy = 1'b1;
    end
    check_outs("step", exp_done);
  endtask

  // gaps: 0 = back-to-back, 1 = random idle cycles, 2 = idle before every char
  task automatic feed(input bq_t q, input int gaps);
    foreach (q[i]) begin
      if (gaps == 2 || (gaps == 1 && $urandom_range(0, 1) == 1)) idle_cycle();
      send_char(q[i]);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_res  = 16'h0;
    m_err  = 1'b0;
    m_busy = 1'b0;
  endtask

  initial begin
    string pool;
    bq_t   rq;
    int    k;
    n_chk    = 0;
    n_fail   = 0;
    pool     = "0123456789+*a#";
    in       = 8'h00;
    in_valid = 1'b0;
    clr      = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 1'b0);
    @(negedge clk);
    clr = 1'b0;

    feed(to_q("3+4*5="), 0);
    chk("r23", {16'd0, result}, 32'd23);
    idle_cycle();
    feed(to_q("2*3+4*5+6="), 2);
    chk("r32", {16'd0, result}, 32'd32);
    feed(to_q("9*9*9*9*9*9="), 0);
    chk("r7153", {16'd0, result}, 32'd7153);
    feed(to_q("3++4="), 0);
    chk("e_pp", {31'd0, err}, 32'd1);
    feed(to_q("7="), 0);
    chk("r7", {16'd0, result}, 32'd7);
    feed(to_q("5*a2="), 0);
    feed(to_q("34="), 0);
    feed(to_q("3+="), 0);
    chk("e_tail", {31'd0, err}, 32'd1);
    // Bare terminator while idle must be ignored.
    feed(to_q("="), 0);
    feed(to_q("6="), 0);

    // Asynchronous clear in the middle of an expression.
    feed(to_q("8*7+"), 0);
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    model_reset();
    check_outs("async_clr", 1'b0);
    #1 clr = 1'b0;
    idle_cycle();
    feed(to_q("1+1="), 0);
    chk("r2", {16'd0, result}, 32'd2);

    for (int n = 0; n < 30; n++) begin
      rq.delete();
      if ($urandom_range(0, 9) < 7) begin
        k = $urandom_range(0, 5);
        for (int j = 0; j < 2 * k + 1; j++) begin
          if (j % 2 == 0) rq.push_back(8'h30 + 8'($urandom_range(0, 9)));
          else rq.push_back(($urandom_range(0, 1) == 1) ? 8'h2A : 8'h2B);
        end
      end else begin
        k = $urandom_range(1, 8);
        for (int j = 0; j < k; j++) rq.push_back(pool[$urandom_range(0, 13)]);
      end
      rq.push_back(8'h3D);
      feed(rq, 1);
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/expr_eval.md
Name: expr_eval

Overview:
- Downstream consumer of the expression-syntax recognizer in pj1. It takes the same 8-bit ASCII character stream: single decimal digits separated by '+' or '*', terminated by '='.
- It evaluates the expression with '*' binding tighter than '+' and reports the result once per terminated expression.
- It checks syntax independently, so an expression is flagged as an error even if no recognizer is present.

Parameters:
- W, 16: width of result and internal accumulators. All arithmetic is modulo 2^W.

Ports:
- clk, input, 1: clock, rising edge.
- clr, input, 1: reset, asynchronous, active-high.
- in, input, 8: ASCII character.
- in_valid, input, 1: when high, `in` is consumed at this rising edge; when low, no state change.
- result, output, W: value of the last terminated expression; held until the next done.
- done, output, 1: one-cycle pulse; result and err are valid in this cycle.
- err, output, 1: syntax status of the last terminated expression; held with result.
- busy, output, 1: high while an expression is partially received (state ≠ S_DIG with no chars taken).

Behaviour:
- Reset (clr=1, async, dominates clk and in_valid):
  - state=S_DIG, sum=0, term=0, mode=NEW.
  - result=0, done=0, err=0, busy=0.
- Character classes:
  - DIG: "0".."9"; value d = in-8'h30.
  - PLUS: "+". STAR: "*". EQ: "=".
  - BAD: anything else.
- Internal registers:
  - sum[W]: committed sum of completed terms.
  - term[W]: current product term.
  - mode ∈ {NEW, MUL}.
- States and transitions, evaluated only on an edge with in_valid=1:
  - S_DIG (expecting a digit):
    - DIG: term <= (mode==NEW) ? d : term*d (truncated to W); go to S_OP.
    - EQ with no chars taken since the last done/reset: ignored, stays idle.
    - Anything else: go to S_ERR.
  - S_OP (expecting an operator):
    - PLUS: sum <= sum+term; mode <= NEW; go to S_DIG.
    - STAR: mode <= MUL; go to S_DIG.
    - EQ: result <= sum+term; err <= 0; done <= 1; clear sum/term; mode <= NEW; go to S_DIG.
    - DIG or BAD: go to S_ERR.
  - S_ERR:
    - All characters are discarded except EQ.
    - EQ: result <= 0; err <= 1; done <= 1; clear sum/term/mode; go to S_DIG.
- EQ arriving in S_DIG after an operator (e.g. "3+=") is an error. It emits done=1, err=1, result=0 on that same terminator; it does not wait for another '='.
- Latency:
  - done rises in the cycle after the edge that sampled EQ.
  - done lasts exactly one cycle, then returns to 0, even if the next char is consumed immediately.
  - Back-to-back expressions are allowed with no idle cycles.
- busy:
  - Goes high on the edge consuming the first char of an expression.
  - Goes low on the edge consuming its EQ.
- in_valid=0 cycles: all registers hold; done, if it was high, still drops after one cycle.
- Overflow: silent wrap modulo 2^W; no error is raised.
- Reset mid-expression: the partial expression is discarded, no done is emitted, and the outputs take their reset values.

Test Plan:
- Reset, then "3+4*5=" one char per cycle -> done pulses one cycle after '=', result=23, err=0, busy low afterward.
- "2*3+4*5+6=" with in_valid low on alternate cycles -> result=32, err=0, exactly one done pulse, no state change on idle cycles.
- "9*9*9*9*9*9=" (W=16) -> result=7153 (531441 mod 65536), err=0.
- "3++4=" -> err=1, result=0, done one pulse. Then "7=" -> result=7, err=0.
- "5*a2=" and "34=" -> each gives done with err=1, result=0. Then "3+=" -> done, err=1, result=0.
- "8*7+" then clr pulsed mid-cycle (async) -> outputs 0 immediately, no done. Then "1+1=" -> result=2.
